// File: rtl/commit_monitor_pkg.sv
// rtl/commit_monitor_pkg.sv - shared types and helpers for the retirement monitor
package commit_monitor_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    DRAIN   = 2'd1,
    HALTED  = 2'd2,
    TIMEOUT = 2'd3
  } mon_state_t;

  localparam int NUM_ARCH_REGS = 32;
  localparam int MAX_LANES     = 4;

  // Callers zero-extend narrower lane vectors to MAX_LANES.
  function automatic logic [2:0] popcount_lanes(input logic [MAX_LANES-1:0] v);
    logic [2:0] n;
    n = '0;
    for (int i = 0; i < MAX_LANES; i++) n = n + {2'b00, v[i]};
    return n;
  endfunction

endpackage

// File: rtl/commit_monitor_if.sv
// rtl/commit_monitor_if.sv - commit channel bundle between the core and the retirement monitor
interface commit_monitor_if #(
  parameter int NUM_LANES = 1,
  parameter int XLEN      = 32,
  parameter int ORDER_W   = 64
);
  logic [NUM_LANES-1:0]         commit_valid;
  logic [NUM_LANES-1:0]         commit_is_ctrl;
  logic [NUM_LANES*XLEN-1:0]    commit_pc_rdata;
  logic [NUM_LANES*XLEN-1:0]    commit_pc_wdata;
  logic [NUM_LANES-1:0]         commit_load_regfile;
  logic [NUM_LANES*5-1:0]       commit_rd_addr;
  logic [NUM_LANES*XLEN-1:0]    commit_rd_wdata;
  logic [NUM_LANES*ORDER_W-1:0] commit_order;

  modport master (
    output commit_valid, commit_is_ctrl, commit_pc_rdata, commit_pc_wdata,
           commit_load_regfile, commit_rd_addr, commit_rd_wdata,
    input  commit_order
  );

  modport slave (
    input  commit_valid, commit_is_ctrl, commit_pc_rdata, commit_pc_wdata,
           commit_load_regfile, commit_rd_addr, commit_rd_wdata,
    output commit_order
  );
endinterface

// File: rtl/commit_order_gen.sv
// rtl/commit_order_gen.sv - dense per-lane order tags from a running base plus prefix popcount
module commit_order_gen
  import commit_monitor_pkg::*;
#(
  parameter int NUM_LANES = 1,
  parameter int ORDER_W   = 64
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_LANES-1:0]         commit_valid,
  output logic [NUM_LANES*ORDER_W-1:0] commit_order,
  output logic [2:0]                   commit_cnt
);

  logic [ORDER_W-1:0]   base_q, base_d;
  logic [MAX_LANES-1:0] valid_ext, older;

  always_comb begin
    valid_ext = '0;
    valid_ext[NUM_LANES-1:0] = commit_valid;
    commit_cnt = popcount_lanes(valid_ext);
    base_d = base_q + ORDER_W'(commit_cnt);
    commit_order = '0;
    older = '0;
    // Each lane's tag skips only the valid lanes older than itself, so gaps stay dense.
    for (int i = 0; i < NUM_LANES; i++) begin
      older = '0;
      for (int j = 0; j < i; j++) older[j] = valid_ext[j];
      commit_order[i*ORDER_W +: ORDER_W] = base_q + ORDER_W'(popcount_lanes(older));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) base_q <= '0;
    else        base_q <= base_d;
  end

endmodule

// File: rtl/commit_monitor.sv
// rtl/commit_monitor.sv - retirement monitor: order tags, retired count, halt/timeout FSM.
// COMMIT_MONITOR_SHADOW_RF_EN adds a 32-entry shadow register file output.
module commit_monitor
  import commit_monitor_pkg::*;
#(
  parameter int NUM_LANES      = 1,
  parameter int XLEN           = 32,
  parameter int ORDER_W        = 64,
  parameter int HALT_REPEAT    = 1,
  parameter int DRAIN_CYCLES   = 4,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic               clk,
  input  logic               reset_n,
  commit_monitor_if.slave    cif,
  output logic [ORDER_W-1:0] retired_count,
  output logic               halt,
  output logic               timeout,
  output mon_state_t         state
`ifdef COMMIT_MONITOR_SHADOW_RF_EN
  ,
  output logic [NUM_ARCH_REGS*XLEN-1:0] shadow_regs
`endif
);

  localparam int RPT_W  = $clog2(HALT_REPEAT + 1);
  localparam int IDLE_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam int DRN_W  = $clog2(DRAIN_CYCLES + 2);
  localparam logic [RPT_W-1:0]  RPT_MAX  = RPT_W'(HALT_REPEAT);
  localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(TIMEOUT_CYCLES);
  localparam logic [DRN_W-1:0]  DRN_INIT = DRN_W'(DRAIN_CYCLES);

  mon_state_t                 state_q, state_d;
  logic [RPT_W-1:0]           rpt_q, rpt_d;
  logic [IDLE_W-1:0]          idle_q, idle_d;
  logic [DRN_W-1:0]           drn_q, drn_d;
  logic [ORDER_W-1:0]         retired_q, retired_d;
  logic                       halt_q, halt_d, timeout_q, timeout_d;
  logic [2:0]                 commit_cnt;
  logic [NUM_LANES*ORDER_W-1:0] order_flat;
  logic                       any_valid, young_loop;

  commit_order_gen #(
    .NUM_LANES (NUM_LANES),
    .ORDER_W   (ORDER_W)
  ) u_order_gen (
    .clk          (clk),
    .rst_n        (reset_n),
    .commit_valid (cif.commit_valid),
    .commit_order (order_flat),
    .commit_cnt   (commit_cnt)
  );

  assign cif.commit_order = order_flat;

  // The youngest valid lane is the last one to overwrite young_loop.
  always_comb begin
    any_valid  = |cif.commit_valid;
    young_loop = 1'b0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (cif.commit_valid[i]) begin
        young_loop = cif.commit_is_ctrl[i] &&
                     (cif.commit_pc_wdata[i*XLEN +: XLEN] == cif.commit_pc_rdata[i*XLEN +: XLEN]);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    rpt_d     = rpt_q;
    idle_d    = idle_q;
    drn_d     = drn_q;
    retired_d = retired_q + ORDER_W'(commit_cnt);
    case (state_q)
      RUN: begin
        if (any_valid) begin
          rpt_d = young_loop ? ((rpt_q == RPT_MAX) ? rpt_q : rpt_q + RPT_W'(1)) : '0;
        end
        if (TIMEOUT_CYCLES != 0) idle_d = any_valid ? '0 : idle_q + IDLE_W'(1);
        // Halt wins: a pending loop trigger is acted on before the idle check.
        if (rpt_q == RPT_MAX) begin
          state_d = DRAIN;
          drn_d   = DRN_INIT;
        end else if ((TIMEOUT_CYCLES != 0) && (idle_d == IDLE_MAX)) begin
          state_d = TIMEOUT;
        end
      end
      DRAIN: begin
        if (drn_q <= DRN_W'(1)) state_d = HALTED;
        else                    drn_d   = drn_q - DRN_W'(1);
      end
      default: ;
    endcase
    halt_d    = halt_q | (state_d == HALTED);
    timeout_d = timeout_q | (state_d == TIMEOUT);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= RUN;
      rpt_q     <= '0;
      idle_q    <= '0;
      drn_q     <= '0;
      retired_q <= '0;
      halt_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rpt_q     <= rpt_d;
      idle_q    <= idle_d;
      drn_q     <= drn_d;
      retired_q <= retired_d;
      halt_q    <= halt_d;
      timeout_q <= timeout_d;
    end
  end

  assign retired_count = retired_q;
  assign halt          = halt_q;
  assign timeout       = timeout_q;
  assign state         = state_q;

`ifdef COMMIT_MONITOR_SHADOW_RF_EN
  logic [NUM_ARCH_REGS-1:0][XLEN-1:0] rf_q, rf_d;

  // Lanes applied oldest first so a younger write to the same rd lands last.
  always_comb begin
    rf_d = rf_q;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (cif.commit_valid[i] && cif.commit_load_regfile[i] &&
          (cif.commit_rd_addr[i*5 +: 5] != 5'd0)) begin
        rf_d[cif.commit_rd_addr[i*5 +: 5]] = cif.commit_rd_wdata[i*XLEN +: XLEN];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rf_q <= '0;
    else          rf_q <= rf_d;
  end

  assign shadow_regs = rf_q;
`else
  logic unused_rf;
  assign unused_rf = ^{cif.commit_load_regfile, cif.commit_rd_addr, cif.commit_rd_wdata};
`endif

endmodule

// File: tb/tb_commit_monitor.sv
// tb/tb_commit_monitor.sv - self-checking bench for commit_monitor against a reference model
module tb_commit_monitor;
  import commit_monitor_pkg::*;

  localparam int LB  = 2;
  localparam int OWB = 8;
  localparam int HRB = 3;
  localparam int DCB = 4;
  localparam int TOB = 10;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  commit_monitor_if #(.NUM_LANES(1),  .XLEN(32), .ORDER_W(64))  if_a ();
  commit_monitor_if #(.NUM_LANES(LB), .XLEN(32), .ORDER_W(OWB)) if_b ();

  logic [63:0]    ret_a;
  logic           halt_a, to_a;
  mon_state_t     st_a;
  logic [OWB-1:0] ret_b;
  logic           halt_b, to_b;
  mon_state_t     st_b;
`ifdef COMMIT_MONITOR_SHADOW_RF_EN
  logic [32*32-1:0] sh_a, sh_b;
`endif

  commit_monitor #(
    .NUM_LANES(1), .XLEN(32), .ORDER_W(64),
    .HALT_REPEAT(1), .DRAIN_CYCLES(4), .TIMEOUT_CYCLES(0)
  ) u_dut_a (
    .clk(clk), .reset_n(rst_n), .cif(if_a.slave),
    .retired_count(ret_a), .halt(halt_a), .timeout(to_a), .state(st_a)
`ifdef COMMIT_MONITOR_SHADOW_RF_EN
    , .shadow_regs(sh_a)
`endif
  );

  commit_monitor #(
    .NUM_LANES(LB), .XLEN(32), .ORDER_W(OWB),
    .HALT_REPEAT(HRB), .DRAIN_CYCLES(DCB), .TIMEOUT_CYCLES(TOB)
  ) u_dut_b (
    .clk(clk), .reset_n(rst_n), .cif(if_b.slave),
    .retired_count(ret_b), .halt(halt_b), .timeout(to_b), .state(st_b)
`ifdef COMMIT_MONITOR_SHADOW_RF_EN
    , .shadow_regs(sh_b)
`endif
  );

  // Reference model for DUT B
  int          m_ret, m_loops, m_idle, m_drain_left;
  mon_state_t  m_mode;
  logic [31:0] m_rf [32];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic reset_model();
    m_ret = 0; m_loops = 0; m_idle = 0; m_drain_left = 0; m_mode = RUN;
    for (int r = 0; r < 32; r++) m_rf[r] = '0;
  endtask

  task automatic clear_a();
    if_a.commit_valid = '0; if_a.commit_is_ctrl = '0;
    if_a.commit_pc_rdata = '0; if_a.commit_pc_wdata = '0;
    if_a.commit_load_regfile = '0; if_a.commit_rd_addr = '0; if_a.commit_rd_wdata = '0;
  endtask

  task automatic clear_b();
    if_b.commit_valid = '0; if_b.commit_is_ctrl = '0;
    if_b.commit_pc_rdata = '0; if_b.commit_pc_wdata = '0;
    if_b.commit_load_regfile = '0; if_b.commit_rd_addr = '0; if_b.commit_rd_wdata = '0;
  endtask

  task automatic lane_b(input int i, input logic v, input logic ctrl,
                        input logic [31:0] pr, input logic [31:0] pw);
    if_b.commit_valid[i] = v;
    if_b.commit_is_ctrl[i] = ctrl;
    if_b.commit_pc_rdata[i*32 +: 32] = pr;
    if_b.commit_pc_wdata[i*32 +: 32] = pw;
  endtask

  task automatic lane_rf_b(input int i, input logic ld, input logic [4:0] rd, input logic [31:0] wd);
    if_b.commit_load_regfile[i] = ld;
    if_b.commit_rd_addr[i*5 +: 5] = rd;
    if_b.commit_rd_wdata[i*32 +: 32] = wd;
  endtask

  // Advance the model across one clock edge using the inputs currently driven on B.
  task automatic model_edge();
    int   n, young;
    logic lp;
    n = 0; young = -1; lp = 1'b0;
    for (int i = LB-1; i >= 0; i--) begin
      if (if_b.commit_valid[i]) begin
        n++;
        if (young < 0) young = i;
      end
    end
    if (young >= 0)
      lp = if_b.commit_is_ctrl[young] &&
           (if_b.commit_pc_rdata[young*32 +: 32] == if_b.commit_pc_wdata[young*32 +: 32]);
    case (m_mode)
      RUN: begin
        if (m_loops == HRB) begin
          m_mode = DRAIN;
          m_drain_left = (DCB > 0) ? DCB : 1;
        end else if (n == 0 && m_idle + 1 == TOB) begin
          m_mode = TIMEOUT;
        end
        if (n > 0) m_loops = lp ? ((m_loops < HRB) ? m_loops + 1 : HRB) : 0;
        m_idle = (n > 0) ? 0 : m_idle + 1;
      end
      DRAIN: begin
        m_drain_left--;
        if (m_drain_left == 0) m_mode = HALTED;
      end
      default: ;
    endcase
    for (int i = 0; i < LB; i++)
      if (if_b.commit_valid[i] && if_b.commit_load_regfile[i] && if_b.commit_rd_addr[i*5 +: 5] != 0)
        m_rf[if_b.commit_rd_addr[i*5 +: 5]] = if_b.commit_rd_wdata[i*32 +: 32];
    m_ret = (m_ret + n) % (1 << OWB);
  endtask

  // Called just after a falling edge with inputs driven: check, advance model, wait a cycle.
  task automatic step_b();
    int below;
    #1;
    check("b_retired", 64'(ret_b), 64'(m_ret));
    check("b_state", 64'(st_b), 64'(m_mode));
    check("b_halt", 64'(halt_b), 64'(m_mode == HALTED));
    check("b_timeout", 64'(to_b), 64'(m_mode == TIMEOUT));
    for (int i = 0; i < LB; i++) begin
      if (if_b.commit_valid[i]) begin
        below = 0;
        for (int j = 0; j < i; j++) below += int'(if_b.commit_valid[j]);
        check("b_order", 64'(if_b.commit_order[i*OWB +: OWB]), 64'((m_ret + below) % (1 << OWB)));
      end
    end
`ifdef COMMIT_MONITOR_SHADOW_RF_EN
    begin
      int idx;
      idx = $urandom_range(0, 31);
      check("b_shadow", 64'(sh_b[idx*32 +: 32]), 64'(m_rf[idx]));
    end
`endif
    model_edge();
    @(negedge clk);
  endtask

  task automatic do_reset();
    clear_b();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    reset_model();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1);
  end

  initial begin
    int pv, pl, len;
    logic [31:0] pr;
    rst_n = 1'b0;
    clear_a(); clear_b(); reset_model();
    @(negedge clk); @(negedge clk);
    #1;
    check("a_rst_retired", ret_a, 64'd0);
    check("a_rst_state", 64'(st_a), 64'(RUN));
    check("a_rst_halt", 64'(halt_a), 64'd0);
    check("b_rst_retired", 64'(ret_b), 64'd0);
    check("b_rst_timeout", 64'(to_b), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single lane: five ordinary commits then a jal-to-self at 0x60
    for (int k = 0; k < 6; k++) begin
      if_a.commit_valid = 1'b1;
      if_a.commit_is_ctrl = (k == 5);
      if_a.commit_pc_rdata = (k == 5) ? 32'h60 : 32'h40 + 32'(4 * k);
      if_a.commit_pc_wdata = (k == 5) ? 32'h60 : 32'h44 + 32'(4 * k);
      #1;
      check("a_order", if_a.commit_order, 64'(k));
      check("a_state_run", 64'(st_a), 64'(RUN));
      @(negedge clk);
    end
    clear_a();
    for (int j = 0; j <= 6; j++) begin
      #1;
      check("a_state_drain", 64'(st_a), (j == 0) ? 64'(RUN) : (j < 5) ? 64'(DRAIN) : 64'(HALTED));
      check("a_halt", 64'(halt_a), 64'(j >= 5));
      @(negedge clk);
    end
    #1 check("a_retired", ret_a, 64'd6);
    @(negedge clk);

    // Two lanes with gaps in the valid vector
    do_reset();
    lane_b(0, 1, 0, 32'h100, 32'h104); lane_b(1, 1, 0, 32'h104, 32'h108);
    #1 check("t2_o0", 64'(if_b.commit_order[0 +: OWB]), 64'd0);
    check("t2_o1", 64'(if_b.commit_order[OWB +: OWB]), 64'd1);
    step_b();
    lane_b(0, 0, 0, 32'h0, 32'h0); lane_b(1, 1, 0, 32'h108, 32'h10c);
    #1 check("t2_o1b", 64'(if_b.commit_order[OWB +: OWB]), 64'd2);
    step_b();
    lane_b(0, 1, 0, 32'h10c, 32'h110); lane_b(1, 0, 0, 32'h0, 32'h0);
    #1 check("t2_o0c", 64'(if_b.commit_order[0 +: OWB]), 64'd3);
    step_b();
    clear_b();
    #1 check("t2_retired", 64'(ret_b), 64'd4);
    step_b();

    // Repeat threshold 3: loop, loop, ordinary, then three loops on the youngest lane
    do_reset();
    for (int k = 0; k < 6; k++) begin
      if (k == 2) lane_b(1, 1, 0, 32'h80, 32'h84);
      else        lane_b(1, 1, 1, 32'h80, 32'h80);
      #1 check("t3_no_drain", 64'(st_b), 64'(RUN));
      step_b();
    end
    clear_b();
    #1 check("t3_run_after_third", 64'(st_b), 64'(RUN));
    step_b();
    #1 check("t3_drain", 64'(st_b), 64'(DRAIN));

    // Asynchronous reset pulse during DRAIN
    #1 rst_n = 1'b0;
    #1;
    check("t5_retired", 64'(ret_b), 64'd0);
    check("t5_state", 64'(st_b), 64'(RUN));
    check("t5_halt", 64'(halt_b), 64'd0);
    check("t5_a_retired", ret_a, 64'd0);
    check("t5_a_state", 64'(st_a), 64'(RUN));
    #1 rst_n = 1'b1;
    reset_model();
    model_edge();
    @(negedge clk);
    lane_b(0, 1, 0, 32'h200, 32'h204);
    #1 check("t5_first_order", 64'(if_b.commit_order[0 +: OWB]), 64'd0);
    step_b();

    // Timeout of 10 idle cycles, restarted by a commit at idle cycle 9
    do_reset();
    lane_b(0, 1, 0, 32'h300, 32'h304);
    step_b();
    clear_b();
    for (int k = 0; k < 8; k++) step_b();
    lane_b(1, 1, 0, 32'h304, 32'h308);
    #1 check("t4_run_before_restart", 64'(st_b), 64'(RUN));
    step_b();
    clear_b();
    for (int k = 1; k <= 10; k++) begin
      #1 check("t4_idle_run", 64'(st_b), 64'(RUN));
      step_b();
    end
    #1 check("t4_state", 64'(st_b), 64'(TIMEOUT));
    check("t4_timeout", 64'(to_b), 64'd1);
    step_b();

`ifdef COMMIT_MONITOR_SHADOW_RF_EN
    do_reset();
    lane_b(0, 1, 0, 32'h400, 32'h404); lane_rf_b(0, 1, 5'd5, 32'h11);
    lane_b(1, 1, 0, 32'h404, 32'h408); lane_rf_b(1, 1, 5'd5, 32'h22);
    step_b();
    clear_b();
    lane_b(0, 1, 0, 32'h408, 32'h40c); lane_rf_b(0, 1, 5'd0, 32'hdead);
    step_b();
    clear_b();
    #1 check("rf_x5", 64'(sh_b[5*32 +: 32]), 64'h22);
    check("rf_x0", 64'(sh_b[0 +: 32]), 64'h0);
    step_b();
`endif

    // Randomized episodes; resets are sparse so the 8-bit counters wrap
    for (int ep = 0; ep < 24; ep++) begin
      if (ep % 4 == 0) do_reset();
      pv  = (ep % 3 == 0) ? 8 : (ep % 3 == 1) ? 50 : 90;
      pl  = $urandom_range(0, 70);
      len = $urandom_range(30, 70);
      for (int c = 0; c < len; c++) begin
        for (int i = 0; i < LB; i++) begin
          pr = 32'($urandom_range(0, 15)) << 2;
          if ($urandom_range(0, 99) < pl)
            lane_b(i, ($urandom_range(0, 99) < pv), 1'b1, pr, pr);
          else
            lane_b(i, ($urandom_range(0, 99) < pv), 1'($urandom_range(0, 1)), pr, pr + 32'd4);
          lane_rf_b(i, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom);
        end
        step_b();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
